// File: rtl/enable_generator_sequencer_pkg.sv
// Shared types and constants for the enable generator sequencer (package enable_gen_pkg).
// Optional burst mode is selected by the ENABLE_SEQUENCER_BURST_EN macro.
package enable_gen_pkg;

    localparam int DEF_COUNTER_WIDTH = 32;
    localparam int DEF_N_CHANNELS    = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        RUNNING  = 2'd2,
        STOPPING = 2'd3
    } seq_state_e;

    // Width of the packed threshold bus; channel k sits at [k*width +: width].
    function automatic int thr_bus_width(input int n_channels, input int width);
        return n_channels * width;
    endfunction

endpackage

// File: rtl/enable_generator_sequencer_if.sv
// Control, configuration and status bundle for the enable generator sequencer.
// burst_length/burst_done exist only when ENABLE_SEQUENCER_BURST_EN is defined.
interface enable_generator_sequencer_if #(
    parameter int COUNTER_WIDTH = enable_gen_pkg::DEF_COUNTER_WIDTH,
    parameter int N_CHANNELS    = enable_gen_pkg::DEF_N_CHANNELS
);
    logic                                start_req;
    logic                                stop_req;
    logic                                sync_mode;
    logic                                ext_sync;
    logic [COUNTER_WIDTH-1:0]            count;
    logic [COUNTER_WIDTH-1:0]            cfg_period;
    logic [N_CHANNELS*COUNTER_WIDTH-1:0] cfg_thresholds;
    logic                                cfg_valid;
    logic                                cfg_ready;
    logic                                gen_enable;
    logic [COUNTER_WIDTH-1:0]            period_out;
    logic [N_CHANNELS*COUNTER_WIDTH-1:0] thresholds_out;
    logic                                running;
    logic                                update_applied;
`ifdef ENABLE_SEQUENCER_BURST_EN
    logic [15:0]                         burst_length;
    logic                                burst_done;
`endif

    modport master (
`ifdef ENABLE_SEQUENCER_BURST_EN
        output burst_length,
        input  burst_done,
`endif
        output start_req, stop_req, sync_mode, ext_sync, count,
        output cfg_period, cfg_thresholds, cfg_valid,
        input  cfg_ready, gen_enable, period_out, thresholds_out,
        input  running, update_applied
    );

    modport slave (
`ifdef ENABLE_SEQUENCER_BURST_EN
        input  burst_length,
        output burst_done,
`endif
        input  start_req, stop_req, sync_mode, ext_sync, count,
        input  cfg_period, cfg_thresholds, cfg_valid,
        output cfg_ready, gen_enable, period_out, thresholds_out,
        output running, update_applied
    );

endinterface

// File: rtl/enable_generator_sequencer_config_shadow.sv
// Shadow/active register pair for period and thresholds with a valid/ready intake.
// The shadow is copied to active while idle, or on the cycle after a period boundary.
module enable_config_shadow
    import enable_gen_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int N_CHANNELS    = DEF_N_CHANNELS
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [COUNTER_WIDTH-1:0]                    cfg_period_i,
    input  logic [thr_bus_width(N_CHANNELS, COUNTER_WIDTH)-1:0] cfg_thresholds_i,
    input  logic                                        cfg_valid_i,
    output logic                                        cfg_ready_o,
    input  logic                                        apply_strobe_i,
    input  logic                                        state_idle_i,
    output logic [COUNTER_WIDTH-1:0]                    period_o,
    output logic [thr_bus_width(N_CHANNELS, COUNTER_WIDTH)-1:0] thresholds_o,
    output logic                                        update_applied_o
);
    localparam int TW = thr_bus_width(N_CHANNELS, COUNTER_WIDTH);

    logic                     full_q;
    logic [COUNTER_WIDTH-1:0] shadow_period_q;
    logic [TW-1:0]            shadow_thr_q;
    logic [COUNTER_WIDTH-1:0] active_period_q;
    logic [TW-1:0]            active_thr_q;
    logic                     applied_q;
    logic                     take;
    logic                     apply;

    // Intake and apply are mutually exclusive: intake needs an empty shadow, apply a full one.
    assign take  = cfg_valid_i && !full_q;
    assign apply = full_q && (state_idle_i || apply_strobe_i);

    always_ff @(posedge clock) begin
        if (reset) begin
            full_q          <= 1'b0;
            shadow_period_q <= '0;
            shadow_thr_q    <= '0;
            active_period_q <= '0;
            active_thr_q    <= '0;
            applied_q       <= 1'b0;
        end else begin
            applied_q <= apply;
            if (take) begin
                shadow_period_q <= cfg_period_i;
                shadow_thr_q    <= cfg_thresholds_i;
                full_q          <= 1'b1;
            end else if (apply) begin
                active_period_q <= shadow_period_q;
                active_thr_q    <= shadow_thr_q;
                full_q          <= 1'b0;
            end
        end
    end

    assign cfg_ready_o      = !full_q;
    assign period_o         = active_period_q;
    assign thresholds_o     = active_thr_q;
    assign update_applied_o = applied_q;

endmodule

// File: rtl/enable_generator_sequencer.sv
// Run/stop sequencer for the enable generator: synced start, graceful stop on a period boundary,
// double-buffered configuration. Define ENABLE_SEQUENCER_BURST_EN for a fixed-length burst mode.
module enable_generator_sequencer
    import enable_gen_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int N_CHANNELS    = DEF_N_CHANNELS
) (
    input logic                         clock,
    input logic                         reset,
    enable_generator_sequencer_if.slave bus
);
    seq_state_e                          state_q;
    logic                                gen_enable_q;
    logic                                running_q;
    logic [COUNTER_WIDTH-1:0]            period_act;
    logic [N_CHANNELS*COUNTER_WIDTH-1:0] thr_act;
    logic                                update_pulse;
    logic                                boundary;
    logic                                state_idle;

    // The counter wraps after reaching period_out, so that cycle closes the period.
    assign boundary   = gen_enable_q && (bus.count == period_act);
    assign state_idle = (state_q == IDLE) || (state_q == ARMED);

    enable_config_shadow #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .N_CHANNELS    (N_CHANNELS)
    ) u_shadow (
        .clock            (clock),
        .reset            (reset),
        .cfg_period_i     (bus.cfg_period),
        .cfg_thresholds_i (bus.cfg_thresholds),
        .cfg_valid_i      (bus.cfg_valid),
        .cfg_ready_o      (bus.cfg_ready),
        .apply_strobe_i   (boundary),
        .state_idle_i     (state_idle),
        .period_o         (period_act),
        .thresholds_o     (thr_act),
        .update_applied_o (update_pulse)
    );

`ifdef ENABLE_SEQUENCER_BURST_EN
    logic [15:0] burst_cnt_q;
    logic        burst_done_q;
    assign bus.burst_done = burst_done_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            gen_enable_q <= 1'b0;
            running_q    <= 1'b0;
`ifdef ENABLE_SEQUENCER_BURST_EN
            burst_cnt_q  <= '0;
            burst_done_q <= 1'b0;
`endif
        end else begin
`ifdef ENABLE_SEQUENCER_BURST_EN
            burst_done_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (bus.start_req) begin
                        if (bus.sync_mode) begin
                            state_q <= ARMED;
                        end else begin
                            state_q      <= RUNNING;
                            gen_enable_q <= 1'b1;
                            running_q    <= 1'b1;
`ifdef ENABLE_SEQUENCER_BURST_EN
                            burst_cnt_q  <= bus.burst_length;
`endif
                        end
                    end
                end
                ARMED: begin
                    // An abort outranks a coincident trigger.
                    if (bus.stop_req) begin
                        state_q <= IDLE;
                    end else if (bus.ext_sync) begin
                        state_q      <= RUNNING;
                        gen_enable_q <= 1'b1;
                        running_q    <= 1'b1;
`ifdef ENABLE_SEQUENCER_BURST_EN
                        burst_cnt_q  <= bus.burst_length;
`endif
                    end
                end
                RUNNING: begin
                    if (bus.stop_req) begin
                        if (boundary) begin
                            state_q      <= IDLE;
                            gen_enable_q <= 1'b0;
                            running_q    <= 1'b0;
                        end else begin
                            state_q <= STOPPING;
                        end
                    end
`ifdef ENABLE_SEQUENCER_BURST_EN
                    else if (boundary && burst_cnt_q != 16'd0) begin
                        if (burst_cnt_q == 16'd1) begin
                            state_q      <= IDLE;
                            gen_enable_q <= 1'b0;
                            running_q    <= 1'b0;
                            burst_done_q <= 1'b1;
                        end
                        burst_cnt_q <= burst_cnt_q - 16'd1;
                    end
`endif
                end
                STOPPING: begin
                    if (bus.start_req) begin
                        state_q <= RUNNING;
                    end else if (boundary) begin
                        state_q      <= IDLE;
                        gen_enable_q <= 1'b0;
                        running_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.gen_enable     = gen_enable_q;
    assign bus.running        = running_q;
    assign bus.period_out     = period_act;
    assign bus.thresholds_out = thr_act;
    assign bus.update_applied = update_pulse;

endmodule

// File: doc/enable_generator_sequencer.md
Name: enable_generator_sequencer

Overview:
- Run/stop and configuration controller placed in front of the enable generator counter and its comparators.
- Sequences start, which can be synchronised to an external trigger, and graceful stop, which always ends on a period boundary.
- Double-buffers the period and threshold values so new settings take effect only at a counter wrap. The counter and comparators never see a mid-period change.

Parameters:
- COUNTER_WIDTH, 32, width of counter, period and thresholds.
- N_CHANNELS, 3, number of enable comparator thresholds managed.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_req  in  1  single-cycle pulse; request generator start
- stop_req  in  1  single-cycle pulse; request stop at next period boundary
- sync_mode  in  1  1 = wait for ext_sync before running; 0 = start immediately
- ext_sync  in  1  external start trigger, single-cycle pulse
- count  in  COUNTER_WIDTH  current counter value from the generator counter
- cfg_period  in  COUNTER_WIDTH  new period value
- cfg_thresholds  in  N_CHANNELS*COUNTER_WIDTH  new thresholds; channel k occupies bits [k*W +: W]
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  shadow buffer empty; configuration accepted on cfg_valid&&cfg_ready
- gen_enable  out  1  drives the counter's gen_enable_in
- period_out  out  COUNTER_WIDTH  active period
- thresholds_out  out  N_CHANNELS*COUNTER_WIDTH  active thresholds
- running  out  1  state is RUNNING or STOPPING
- update_applied  out  1  one-cycle pulse when shadow is copied to active

Behaviour:
- Reset values:
  - state IDLE; gen_enable=0; running=0; update_applied=0.
  - period_out=0; thresholds_out=0.
  - shadow empty, so cfg_ready=1.
- Period boundary: boundary = gen_enable && (count == period_out). The counter runs 0..period_out and then wraps to 0.
- FSM states:
  - IDLE: gen_enable=0.
    - start_req && !sync_mode -> RUNNING.
    - start_req && sync_mode -> ARMED.
  - ARMED: gen_enable=0.
    - ext_sync -> RUNNING.
    - stop_req -> IDLE (abort).
    - ext_sync and stop_req in the same cycle: stop wins.
  - RUNNING: gen_enable=1.
    - stop_req -> STOPPING.
    - stop_req coincident with boundary -> IDLE directly.
  - STOPPING: gen_enable=1.
    - boundary -> IDLE; gen_enable falls in the cycle after the boundary.
    - start_req in STOPPING cancels the stop -> RUNNING.
- Output timing: gen_enable and running are registered. Transition to RUNNING means gen_enable=1 on the next clock edge (1-cycle latency from start_req/ext_sync).
- Configuration handshake:
  - A transfer occurs on cfg_valid && cfg_ready. The shadow registers latch period and thresholds and are marked full; cfg_ready drops the next cycle.
  - Apply, while shadow full:
    - State IDLE or ARMED: apply on the next cycle.
    - State RUNNING/STOPPING: apply on the cycle after a boundary, so new values are live when count=0.
  - On apply: active <= shadow; shadow empty; cfg_ready=1; update_applied pulses for 1 cycle.
  - A boundary coinciding with a transfer applies nothing: the shadow is still empty in that cycle, so the new values wait for the following boundary.
  - Apply and a new transfer cannot coincide, because cfg_ready=0 while full.
- Widths: straight copies, no arithmetic beyond the equality compare.
- period_out=0 while running: boundary fires every cycle. This is legal; updates apply on the next cycle.
- Reset mid-operation: returns to IDLE immediately. Shadow and active values are cleared and any pending update is discarded.

Optional Feature:
- Macro: ENABLE_SEQUENCER_BURST_EN.
- Defined:
  - Adds input burst_length [15:0] and output burst_done (1-cycle pulse).
  - On entry to RUNNING, a period counter loads burst_length. Each boundary decrements it.
  - When it reaches 0 at a boundary: -> IDLE and pulse burst_done.
  - burst_length=0 means continuous operation.
  - stop_req still takes priority (-> STOPPING as normal).
- Undefined: no extra ports; the generator runs until stop_req.

Decomposition:
- Shared package enable_gen_pkg:
  - typedef enum of sequencer states (IDLE, ARMED, RUNNING, STOPPING).
  - Default COUNTER_WIDTH constant.
  - Threshold bus slicing helper/constant.
- Sub-module enable_config_shadow: holds the shadow/active register pair and the valid/ready handshake. Inputs are apply_strobe and state_idle. The FSM stays in the top level.

Test Plan:
- Immediate start/stop: sync_mode=0, period_out=9, start_req at t0 -> gen_enable=1 at t0+1. stop_req while count=3 -> gen_enable stays 1 through count=9, low the next cycle; running=0.
- Synced start and abort:
  - sync_mode=1, start_req -> ARMED, gen_enable=0. ext_sync 20 cycles later -> gen_enable=1 the next cycle.
  - Repeat with stop_req and ext_sync in the same cycle -> IDLE, gen_enable never asserts.
- Shadowed update:
  - Running, period=9. Offer cfg_period=4, thresholds {1,2,3} at count=2 -> cfg_ready=0.
  - period_out stays 9 until count=9. update_applied pulses when count=0, and period_out=4 from then on.
- Update in IDLE: cfg_valid with period 15 -> period_out=15 and update_applied two cycles after the transfer; cfg_ready returns to 1.
- Corner cases:
  - stop_req exactly on boundary -> IDLE the next cycle, no extra period.
  - start_req during STOPPING -> continues RUNNING.
  - reset during STOPPING with shadow full -> all outputs 0, cfg_ready=1.
- Burst (macro defined): burst_length=3, period=4 -> gen_enable high for exactly 15 cycles; burst_done pulses once at the third boundary.
